// File: rtl/baccarat_pkg.sv
//------------------------------------------------------------------------------
// Module : baccarat_pkg
// Brief  : Shared state encoding and rule thresholds for the baccarat sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package baccarat_pkg;

    typedef enum logic [3:0] {
        DEAL_P1  = 4'd0,
        DEAL_D1  = 4'd1,
        DEAL_P2  = 4'd2,
        DEAL_D2  = 4'd3,
        DECIDE_P = 4'd4,
        DEAL_P3  = 4'd5,
        DECIDE_D = 4'd6,
        DEAL_D3  = 4'd7,
        SCORE    = 4'd8,
        RESULT   = 4'd9
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    localparam logic [3:0] DEALER_STAND     = 4'd7;
    localparam logic [3:0] RANK_TEN         = 4'd10;

endpackage

`default_nettype wire

// File: rtl/baccarat_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : baccarat_sequencer_if
// Brief  : Sequencer <-> datapath bundle: step, scores, card loads and lights.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface baccarat_sequencer_if;
    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       done;

    // Sequencer side
    modport master (
        input  step, pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, done
    );

    // Datapath / environment side
    modport slave (
        output step, pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, done
    );
endinterface

`default_nettype wire

// File: rtl/baccarat_sequencer_banker_rule.sv
//------------------------------------------------------------------------------
// Module : banker_rule
// Brief  : Combinational banker third-card decision.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module banker_rule
    import baccarat_pkg::*;
(
    input  wire logic [3:0] dscore,
    input  wire logic [3:0] pcard3,
    input  wire logic       player_drew,
    output logic            draw
);

    logic [3:0] w_v;

    // Tens and court cards count as zero.
    assign w_v = (pcard3 >= RANK_TEN) ? 4'd0 : pcard3;

    always_comb begin
        draw = 1'b0;
        if (!player_drew) begin
            draw = (dscore < PLAYER_STAND_MIN);
        end else begin
            case (dscore)
                4'd0, 4'd1, 4'd2: draw = 1'b1;
                4'd3:             draw = (w_v != 4'd8);
                4'd4:             draw = (w_v >= 4'd2) && (w_v <= 4'd7);
                4'd5:             draw = (w_v >= 4'd4) && (w_v <= 4'd7);
                4'd6:             draw = (w_v >= 4'd6) && (w_v <= 4'd7);
                default:          draw = (dscore < DEALER_STAND);
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/baccarat_sequencer.sv
//------------------------------------------------------------------------------
// Module : baccarat_sequencer
// Brief  : Deal-order FSM issuing card loads, third-card rules and winner lights.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module baccarat_sequencer
    import baccarat_pkg::*;
(
    input  wire logic            slow_clock,
    input  wire logic            reset,
    baccarat_sequencer_if.master bus
);

    state_t r_state;
    state_t w_next_state;
    logic   r_player_drew;
    logic   r_player_win;
    logic   r_dealer_win;
    logic   r_done;
    logic   w_dealer_draw;
    logic   w_natural;
    logic   w_player_low;
    logic   w_go;
    logic   w_load_p1, w_load_p2, w_load_p3;
    logic   w_load_d1, w_load_d2, w_load_d3;

    assign w_natural    = (bus.pscore >= NATURAL_MIN) || (bus.dscore >= NATURAL_MIN);
    assign w_player_low = (bus.pscore < PLAYER_STAND_MIN);
    // Reset dominates: no load may fire in a reset cycle.
    assign w_go         = bus.step && !reset;

    banker_rule u_banker_rule (
        .dscore      (bus.dscore),
        .pcard3      (bus.pcard3),
        .player_drew (r_player_drew),
        .draw        (w_dealer_draw)
    );

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_state <= DEAL_P1;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DEAL_P1:  if (bus.step) w_next_state = DEAL_D1;
            DEAL_D1:  if (bus.step) w_next_state = DEAL_P2;
            DEAL_P2:  if (bus.step) w_next_state = DEAL_D2;
            DEAL_D2:  if (bus.step) w_next_state = DECIDE_P;
            DECIDE_P: begin
                if (w_natural)         w_next_state = SCORE;
                else if (w_player_low) w_next_state = DEAL_P3;
                else                   w_next_state = DECIDE_D;
            end
            DEAL_P3:  if (bus.step) w_next_state = DECIDE_D;
            DECIDE_D: w_next_state = w_dealer_draw ? DEAL_D3 : SCORE;
            DEAL_D3:  if (bus.step) w_next_state = SCORE;
            SCORE:    w_next_state = RESULT;
            RESULT:   w_next_state = RESULT;
            default:  w_next_state = DEAL_P1;
        endcase
    end

    always_comb begin
        w_load_p1 = 1'b0;
        w_load_p2 = 1'b0;
        w_load_p3 = 1'b0;
        w_load_d1 = 1'b0;
        w_load_d2 = 1'b0;
        w_load_d3 = 1'b0;
        if (w_go) begin
            case (r_state)
                DEAL_P1: w_load_p1 = 1'b1;
                DEAL_D1: w_load_d1 = 1'b1;
                DEAL_P2: w_load_p2 = 1'b1;
                DEAL_D2: w_load_d2 = 1'b1;
                DEAL_P3: w_load_p3 = 1'b1;
                DEAL_D3: w_load_d3 = 1'b1;
                default: ;
            endcase
        end
    end

    // Ties light both lamps, hence the non-strict compares.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_player_drew <= 1'b0;
            r_player_win  <= 1'b0;
            r_dealer_win  <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (r_state == DECIDE_P) begin
                r_player_drew <= !w_natural && w_player_low;
            end
            if (r_state == SCORE) begin
                r_player_win <= (bus.pscore >= bus.dscore);
                r_dealer_win <= (bus.dscore >= bus.pscore);
                r_done       <= 1'b1;
            end
        end
    end

    assign bus.load_pcard1      = w_load_p1;
    assign bus.load_pcard2      = w_load_p2;
    assign bus.load_pcard3      = w_load_p3;
    assign bus.load_dcard1      = w_load_d1;
    assign bus.load_dcard2      = w_load_d2;
    assign bus.load_dcard3      = w_load_d3;
    assign bus.player_win_light = r_player_win;
    assign bus.dealer_win_light = r_dealer_win;
    assign bus.done             = r_done;

endmodule

`default_nettype wire
